// File: rtl/alu_pkg.sv
// ALU/decode shared definitions for the RV32I integer pipeline.
//   alu_op_t      : operation codes consumed by the execute stage
//   OPC_*         : major opcodes handled by the decode stage
//   FUNCT7_*      : funct7 patterns selecting base vs. alternate operations
//   decode_t      : result of instruction classification
//   decode_instr  : classifies one instruction word into decode_t
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic    illegal;
    alu_op_t op;
    logic    use_imm;  // operand_b comes from the I-type immediate
  } decode_t;

  // funct3 -> operation for the base (funct7 = 0) encodings, shared by OP and OP-IMM.
  function automatic alu_op_t base_op(input logic [2:0] funct3);
    alu_op_t op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t    d;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    opcode    = instr[6:0];
    funct3    = instr[14:12];
    funct7    = instr[31:25];
    d.illegal = 1'b0;
    d.op      = ALU_ADD;
    d.use_imm = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == FUNCT7_BASE)
          d.op = base_op(funct3);
        else if (funct7 == FUNCT7_ALT && funct3 == 3'b000)
          d.op = ALU_SUB;
        else if (funct7 == FUNCT7_ALT && funct3 == 3'b101)
          d.op = ALU_SRA;
        else
          d.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        d.use_imm = 1'b1;
        d.op      = base_op(funct3);
        // Shift immediates reuse imm[11:5] as a funct7 selector.
        if (funct3 == 3'b001 && funct7 != FUNCT7_BASE)
          d.illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == FUNCT7_ALT)
            d.op = ALU_SRA;
          else if (funct7 != FUNCT7_BASE)
            d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal beats are emitted as a harmless ADD of zeros.
    if (d.illegal) begin
      d.op      = ALU_ADD;
      d.use_imm = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Bundle of the decode stage's handshake and data signals.
//   instruction side : in_valid, in_ready, instruction
//   write-back side  : wb_en, wb_rd, wb_data
//   execute side     : out_valid, out_ready, operand_a/b, alu_op,
//                      rd_addr, rs1_addr, rs2_addr, illegal_instr
// modport slave  : the decode stage itself
// modport master : the surrounding pipeline (fetch, write-back, execute)
interface decode_operand_stage_if
  import alu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  alu_op_t         alu_op;
  logic [4:0]      rd_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            illegal_instr;

  modport master (
    output in_valid, instruction, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, alu_op,
           rd_addr, rs1_addr, rs2_addr, illegal_instr
  );

  modport slave (
    input  in_valid, instruction, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, operand_a, operand_b, alu_op,
           rd_addr, rs1_addr, rs2_addr, illegal_instr
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port.
//   clk, reset           : clock, asynchronous active-low reset (clears all entries)
//   rs1_addr / rs1_data  : read port 1
//   rs2_addr / rs2_data  : read port 2
//   wb_en, wb_rd, wb_data: write port, takes effect on the rising edge
// x0 always reads zero; a write in flight to the register being read is
// forwarded to the read data in the same cycle.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  logic [XLEN-1:0]      regs_reg [NREGS];
  logic [1:0][4:0]      rd_addr;
  logic [1:0][XLEN-1:0] rd_data;
  logic                 wr_active;

  // Entry 0 is cleared on reset and never written, so it stays zero.
  assign wr_active = wb_en && (wb_rd != 5'd0) && (int'(wb_rd) < NREGS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (wr_active) begin
      regs_reg[wb_rd] <= wb_data;
    end
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      assign rd_data[gi] =
        (rd_addr[gi] == 5'd0 || int'(rd_addr[gi]) >= NREGS) ? '0 :
        (wr_active && wb_rd == rd_addr[gi])                 ? wb_data :
                                                              regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

endmodule

// File: rtl/decode_operand_stage.sv
// First stage of the 3-stage ALU pipeline: decodes RV32I OP / OP-IMM
// instructions, reads operands from the register file and registers them
// for the execute stage.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of decode_operand_stage_if (instruction handshake,
//           write-back port, registered execute-stage outputs)
// Latency 1, throughput 1; the output register stalls only on out_ready=0.
module decode_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  decode_operand_stage_if.slave  bus
);
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_sext;
  decode_t         dec;
  logic            accept;

  logic            out_valid_reg;
  logic [XLEN-1:0] operand_a_reg, operand_a_next;
  logic [XLEN-1:0] operand_b_reg, operand_b_next;
  alu_op_t         alu_op_reg, alu_op_next;
  logic [4:0]      rd_addr_reg, rd_addr_next;
  logic [4:0]      rs1_addr_reg, rs1_addr_next;
  logic [4:0]      rs2_addr_reg, rs2_addr_next;
  logic            illegal_reg, illegal_next;

  assign rs1_idx  = bus.instruction[19:15];
  assign rs2_idx  = bus.instruction[24:20];
  assign rd_idx   = bus.instruction[11:7];
  assign imm_sext = {{(XLEN-12){bus.instruction[31]}}, bus.instruction[31:20]};
  assign dec      = decode_instr(bus.instruction);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1_idx),
    .rs1_data (rs1_val),
    .rs2_addr (rs2_idx),
    .rs2_data (rs2_val),
    .wb_en    (bus.wb_en),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data)
  );

  always_comb begin
    operand_a_next = rs1_val;
    operand_b_next = dec.use_imm ? imm_sext : rs2_val;
    alu_op_next    = dec.op;
    rd_addr_next   = rd_idx;
    rs1_addr_next  = rs1_idx;
    rs2_addr_next  = dec.use_imm ? 5'd0 : rs2_idx;
    illegal_next   = dec.illegal;
    // Illegal beats carry no register traffic, so execute never forwards
    // into or out of them.
    if (dec.illegal) begin
      operand_a_next = '0;
      operand_b_next = '0;
      rd_addr_next   = 5'd0;
      rs1_addr_next  = 5'd0;
      rs2_addr_next  = 5'd0;
    end
  end

  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      alu_op_reg    <= ALU_ADD;
      rd_addr_reg   <= 5'd0;
      rs1_addr_reg  <= 5'd0;
      rs2_addr_reg  <= 5'd0;
      illegal_reg   <= 1'b0;
    end else begin
      // While stalled (out_valid && !out_ready) in_ready is low and nothing moves.
      if (bus.in_ready) out_valid_reg <= bus.in_valid;
      if (accept) begin
        operand_a_reg <= operand_a_next;
        operand_b_reg <= operand_b_next;
        alu_op_reg    <= alu_op_next;
        rd_addr_reg   <= rd_addr_next;
        rs1_addr_reg  <= rs1_addr_next;
        rs2_addr_reg  <= rs2_addr_next;
        illegal_reg   <= illegal_next;
      end
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.operand_a     = operand_a_reg;
  assign bus.operand_b     = operand_b_reg;
  assign bus.alu_op        = alu_op_reg;
  assign bus.rd_addr       = rd_addr_reg;
  assign bus.rs1_addr      = rs1_addr_reg;
  assign bus.rs2_addr      = rs2_addr_reg;
  assign bus.illegal_instr = illegal_reg;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Self-checking bench for decode_operand_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the stage.
module tb_decode_operand_stage;

  logic clk;
  logic reset;

  decode_operand_stage_if #(.XLEN(32)) bus ();

  decode_operand_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference state: architectural registers plus the expected output beat.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic        m_ill;
  int          m_op;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd, m_rs1, m_rs2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 0;  // ADD
      3'd1: return 2;  // SLL
      3'd2: return 3;  // SLT
      3'd3: return 4;  // SLTU
      3'd4: return 5;  // XOR
      3'd5: return 6;  // SRL
      3'd6: return 8;  // OR
      default: return 9;  // AND
    endcase
  endfunction

  // Architectural view of the decode rules.
  task automatic model_decode(input logic [31:0] ins, input logic [31:0] ra, input logic [31:0] rb);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    m_ill = 1'b1; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin m_ill = 1'b0; m_op = base_op(f3); end
      else if (f7 == 7'h20 && f3 == 3'd0) begin m_ill = 1'b0; m_op = 1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin m_ill = 1'b0; m_op = 7; end
      if (!m_ill) begin
        m_a = ra; m_b = rb; m_rd = ins[11:7]; m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
      end
    end else if (opc == 7'h13) begin
      m_ill = 1'b0;
      m_op  = base_op(f3);
      if (f3 == 3'd1 && f7 != 7'h00) m_ill = 1'b1;
      if (f3 == 3'd5) begin
        if (f7 == 7'h20) m_op = 7;
        else if (f7 != 7'h00) m_ill = 1'b1;
      end
      if (m_ill) m_op = 0;
      else begin
        m_a = ra; m_b = {{20{ins[31]}}, ins[31:20]}; m_rd = ins[11:7]; m_rs1 = ins[19:15]; m_rs2 = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 0; m_ill = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    logic        exp_rdy;
    logic [31:0] ra, rb;
    bus.in_valid    = iv;
    bus.instruction = ins;
    bus.out_ready   = ordy;
    bus.wb_en       = we;
    bus.wb_rd       = wrd;
    bus.wb_data     = wd;
    #1;
    exp_rdy = !m_valid || ordy;
    check_val("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    if (exp_rdy) begin
      if (iv) begin
        // A write landing this cycle is visible to the read.
        ra = (ins[19:15] == 0) ? 32'h0 : (we && wrd == ins[19:15]) ? wd : m_regs[ins[19:15]];
        rb = (ins[24:20] == 0) ? 32'h0 : (we && wrd == ins[24:20]) ? wd : m_regs[ins[24:20]];
        model_decode(ins, ra, rb);
        n_txn++;
        $display("txn %0d: instr=%08h ill=%0d op=%0d a=%08h b=%08h rd=%0d", n_txn, ins, m_ill, m_op, m_a, m_b, m_rd);
      end
      m_valid = iv;
    end
    if (we && wrd != 0) m_regs[wrd] = wd;
    @(posedge clk);
    @(negedge clk);
    check_val("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check_val("illegal_instr", {31'b0, bus.illegal_instr}, {31'b0, m_ill});
      check_val("alu_op", {28'b0, bus.alu_op}, m_op);
      check_val("operand_a", bus.operand_a, m_a);
      check_val("operand_b", bus.operand_b, m_b);
      check_val("rd_addr", {27'b0, bus.rd_addr}, {27'b0, m_rd});
      if (!m_ill) begin
        check_val("rs1_addr", {27'b0, bus.rs1_addr}, {27'b0, m_rs1});
        check_val("rs2_addr", {27'b0, bus.rs2_addr}, {27'b0, m_rs2});
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 3) begin
      w[6:0]   = 7'h33;
      w[31:25] = f7;
    end else if (k <= 7) begin
      w[6:0] = 7'h13;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = f7;
    end
    return w;
  endfunction

  logic [31:0] instr_a, instr_b;

  initial begin
    model_reset();
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0;
    bus.out_ready   = 1'b1;
    bus.wb_en       = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state of the output register.
    check_val("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check_val("rst_operand_a", bus.operand_a, 32'h0);
    check_val("rst_operand_b", bus.operand_b, 32'h0);
    check_val("rst_alu_op", {28'b0, bus.alu_op}, 32'h0);
    check_val("rst_rd_addr", {27'b0, bus.rd_addr}, 32'h0);
    check_val("rst_illegal", {31'b0, bus.illegal_instr}, 32'h0);

    // x1 = 10, x2 = 20, then ADD x3,x1,x2.
    cycle(0, 32'h0, 1, 1, 5'd1, 32'd10);
    cycle(0, 32'h0, 1, 1, 5'd2, 32'd20);
    cycle(1, 32'h002081B3, 1, 0, 5'd0, 32'h0);
    check_val("add_operand_a", bus.operand_a, 32'd10);
    check_val("add_operand_b", bus.operand_b, 32'd20);
    check_val("add_rd_addr", {27'b0, bus.rd_addr}, 32'd3);

    // ADDI x5,x1,-1.
    cycle(1, 32'hFFF08293, 1, 0, 5'd0, 32'h0);
    check_val("addi_operand_b", bus.operand_b, 32'hFFFFFFFF);
    check_val("addi_rs2_addr", {27'b0, bus.rs2_addr}, 32'h0);

    // SUB x4,x1,x2 while x1 is being written: bypass.
    cycle(1, 32'h40208233, 1, 1, 5'd1, 32'h55);
    check_val("sub_bypass_a", bus.operand_a, 32'h55);
    check_val("sub_alu_op", {28'b0, bus.alu_op}, 32'd1);

    // Backpressure: A loads, B is offered for 3 stalled cycles, then accepted once.
    instr_a = {7'h00, 5'd2, 5'd1, 3'b000, 5'd8, 7'h33};
    instr_b = {7'h00, 5'd1, 5'd2, 3'b100, 5'd9, 7'h33};
    cycle(1, instr_a, 1, 0, 5'd0, 32'h0);
    repeat (3) cycle(1, instr_b, 0, 0, 5'd0, 32'h0);
    check_val("stall_holds_rd", {27'b0, bus.rd_addr}, 32'd8);
    cycle(1, instr_b, 1, 0, 5'd0, 32'h0);
    check_val("release_rd", {27'b0, bus.rd_addr}, 32'd9);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'h0);

    // Illegal encodings.
    cycle(1, 32'h0000007F, 1, 0, 5'd0, 32'h0);
    check_val("illegal_opc", {31'b0, bus.illegal_instr}, 32'h1);
    cycle(1, {7'b0100001, 5'd1, 5'd1, 3'b101, 5'd5, 7'h13}, 1, 0, 5'd0, 32'h0);
    check_val("illegal_srai", {31'b0, bus.illegal_instr}, 32'h1);
    check_val("illegal_srai_rd", {27'b0, bus.rd_addr}, 32'h0);

    // x0 ignores writes.
    cycle(0, 32'h0, 1, 1, 5'd0, 32'hDEAD);
    cycle(1, {7'h00, 5'd0, 5'd0, 3'b000, 5'd6, 7'h33}, 1, 1, 5'd0, 32'hBEEF);
    check_val("x0_operand_a", bus.operand_a, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
    end

    // Asynchronous reset while a beat is held under backpressure.
    cycle(1, instr_a, 0, 0, 5'd0, 32'h0);
    cycle(1, instr_b, 0, 0, 5'd0, 32'h0);
    check_val("pre_reset_valid", {31'b0, bus.out_valid}, 32'h1);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_val("async_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check_val("async_operand_a", bus.operand_a, 32'h0);
    model_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    cycle(1, {7'h00, 5'd2, 5'd1, 3'b000, 5'd7, 7'h33}, 1, 0, 5'd0, 32'h0);
    check_val("post_reset_x1", bus.operand_a, 32'h0);
    check_val("post_reset_x2", bus.operand_b, 32'h0);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
